ram_8x8_arbiter: RTL
====================

# ram_8x8_arbiter

Two-requester arbiter and sequencer for the shared `ram_8x8` synchronous RAM. It accepts independent read/write requests from two clients and selects one per transaction. It drives the RAM's single address/data/enable port with registered signals, and returns read data to the owning client with a valid pulse. It sits directly in front of `ram_8x8`; no other block drives the RAM ports.

## Interface
- `ADDR_W`, default 3: RAM address width (8 words).
- `DATA_W`, default 8: RAM data width.

- `clk`  in  1  single clock for the arbiter and the RAM.
- `reset`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  client transaction request; held until grant.
- `we0` / `we1`  in  1  1 = write, 0 = read; valid while req high.
- `addr0` / `addr1`  in  ADDR_W  client word address.
- `wdata0` / `wdata1`  in  DATA_W  client write data.
- `gnt0` / `gnt1`  out  1  one-cycle grant pulse; the command is being issued to the RAM this cycle.
- `rvalid0` / `rvalid1`  out  1  one-cycle read-data-valid pulse.
- `rdata`  out  DATA_W  registered read data, shared by both clients; qualified by rvalid0/1.
- `ram_address`  out  ADDR_W  to RAM `address`.
- `ram_data_in`  out  DATA_W  to RAM `data_in`.
- `ram_write_enable`  out  1  to RAM `write_enable`.
- `ram_read_enable`  out  1  to RAM `read_enable`.
- `ram_data_out`  in  DATA_W  from RAM `data_out`; valid the cycle after a read-enabled edge.

## Operation
- FSM states: IDLE, ISSUE, RDATA.
- IDLE: if req0|req1, pick the winner, then register the winner's addr/wdata/we into the RAM outputs and the owner id. Next state ISSUE. With no request, stay in IDLE with both RAM enables 0.
- ISSUE: exactly one of ram_write_enable / ram_read_enable is high. gnt of the owner is high. Write goes to IDLE next; read goes to RDATA next.
- RDATA: both RAM enables 0. At the closing edge, rdata <= ram_data_out and rvalid of the owner <= 1 for one cycle. Next state IDLE.
- Requests are sampled only in IDLE. The client holds req/we/addr/wdata stable up to and including its gnt cycle. It deasserts req at the edge ending gnt. A req still high in IDLE after gnt is a new transaction.
- Arbitration with both requesting uses fixed priority: client 0 wins, unless RAM_ARB_RR_EN is defined (see Configuration).
- ram_address and ram_data_in hold their last values when idle. Only the enables are forced to 0.
- No address arithmetic; addresses pass through unchanged (0..7).

## Timing
- Reset values (async, immediate): state IDLE; all gnt/rvalid 0; rdata 0; ram_address 0; ram_data_in 0; both RAM enables 0; round-robin pointer = client 1 last served.
- Write: req sampled at edge E0 → ISSUE cycle (gnt, write_enable) → RAM writes at E1 → IDLE. Occupancy is 2 cycles.
- Read: E0 sample → ISSUE (gnt, read_enable) → RAM reads at E1 → RDATA → rdata/rvalid registered at E2 and visible for one cycle. Occupancy is 3 cycles.
- The rvalid cycle coincides with IDLE, so a new request is sampled at the same edge that ends rvalid. Back-to-back transactions are permitted.
- RAM enables are never high in two consecutive cycles. Write and read enables are never high together.
- Reset mid-transaction aborts it. No gnt or rvalid is produced for it, and the enables drop immediately.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin arbitration. On contention, the client not served last wins. A 1-bit last-served pointer updates on every grant. The first contention after reset goes to client 0.
- Undefined: fixed priority with client 0 always winning; the pointer logic is not built. Client 1 can starve under continuous client-0 traffic.

## Structure
- Package `ram_8x8_pkg`: ADDR_W/DATA_W constants, FSM state enum (IDLE, ISSUE, RDATA), owner id type.
- One sub-module, `ram_arb_pick`: combinational winner select from req0/req1 and the last-served pointer, with the pointer register gated by RAM_ARB_RR_EN.

## Test plan
- After reset release, client 0 writes 8'hA5 to addr 1 → gnt0 one cycle, ram_write_enable one cycle with ram_address 1 and ram_data_in A5.
- Client 0 reads addr 1 → gnt0, then rvalid0 two cycles after gnt0 with rdata = 8'hA5.
- Both clients request in the same cycle (c0 write 8'h3C @2, c1 write 8'hF0 @4):
  - Fixed priority: gnt0 first, then gnt1.
  - With RAM_ARB_RR_EN: repeat the contention and check that grants alternate c0, c1, c0, c1.
- Client 1 reads addr 4 while client 0 waits with a read of addr 2 → rvalid1 rdata F0, then rvalid0 rdata 3C. rvalid0 and rvalid1 are never high together.
- Assert reset during the ISSUE cycle of a read → enables and gnt drop immediately, no rvalid follows, and state is IDLE after release.
- Continuous back-to-back reads from client 0 → one grant every 3 cycles and no overlapping RAM enables. Without the macro, client 1 is never granted.

Source files
------------

// File: rtl/ram_8x8_pkg.sv
// Shared definitions for the ram_8x8 arbiter: default RAM geometry,
// sequencer state encoding and the client owner id.
package ram_8x8_pkg;

    localparam int RAM_ADDR_W = 3;
    localparam int RAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    // Owner id: 0 = client 0, 1 = client 1.
    typedef logic owner_t;

    localparam owner_t OWNER_C0 = 1'b0;
    localparam owner_t OWNER_C1 = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select between the two clients.
// Build option RAM_ARB_RR_EN: when defined, contention is resolved
// round-robin using a 1-bit last-served pointer; otherwise client 0
// always wins and no pointer register exists.
module ram_arb_pick
    import ram_8x8_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   req0,
    input  logic   req1,
    input  logic   grant_fire,
    output owner_t winner
);

`ifdef RAM_ARB_RR_EN
    owner_t last_q;
    owner_t last_d;

    // Contention goes to the client not served last; a lone request wins outright.
    always_comb begin
        winner = OWNER_C0;
        last_d = last_q;
        if (req0 && req1) begin
            winner = ~last_q;
        end else if (req1) begin
            winner = OWNER_C1;
        end
        if (grant_fire) begin
            last_d = winner;
        end
    end

    // Last-served pointer; starts as "client 1 served" so client 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= OWNER_C1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_sig;

    // Fixed priority: client 1 wins only when client 0 is not requesting.
    always_comb begin
        winner = (req1 && !req0) ? OWNER_C1 : OWNER_C0;
    end

    assign unused_sig = ^{clk, reset, grant_fire};
`endif

endmodule

// File: rtl/ram_8x8_arbiter.sv
// Two-client arbiter/sequencer in front of the ram_8x8 synchronous RAM.
// IDLE samples requests and registers the winner's command, ISSUE drives
// exactly one RAM enable for one cycle, RDATA captures the read data.
// Build option RAM_ARB_RR_EN selects round-robin arbitration (see ram_arb_pick).
module ram_8x8_arbiter
    import ram_8x8_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    input  logic [DATA_W-1:0] ram_data_out
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              ren_q, ren_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              grant_fire;
    owner_t            winner;

    ram_arb_pick u_pick (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .grant_fire (grant_fire),
        .winner     (winner)
    );

    // Next-state and registered-output logic for the three-state sequencer.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wen_d      = 1'b0;
        ren_d      = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata_d    = rdata_q;
        grant_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_fire = 1'b1;
                    owner_d    = winner;
                    state_d    = ISSUE;
                    if (winner == OWNER_C1) begin
                        addr_d  = addr1;
                        wdata_d = wdata1;
                        wen_d   = we1;
                        ren_d   = ~we1;
                    end else begin
                        addr_d  = addr0;
                        wdata_d = wdata0;
                        wen_d   = we0;
                        ren_d   = ~we0;
                    end
                end
            end
            ISSUE: begin
                state_d = wen_q ? IDLE : RDATA;
            end
            RDATA: begin
                rdata_d   = ram_data_out;
                rvalid0_d = (owner_q == OWNER_C0);
                rvalid1_d = (owner_q == OWNER_C1);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_C0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            ren_q     <= ren_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata_q   <= rdata_d;
        end
    end

    assign gnt0             = (state_q == ISSUE) && (owner_q == OWNER_C0);
    assign gnt1             = (state_q == ISSUE) && (owner_q == OWNER_C1);
    assign rvalid0          = rvalid0_q;
    assign rvalid1          = rvalid1_q;
    assign rdata            = rdata_q;
    assign ram_address      = addr_q;
    assign ram_data_in      = wdata_q;
    assign ram_write_enable = wen_q;
    assign ram_read_enable  = ren_q;

endmodule
